// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: one DATA_WIDTH adder sequenced LSW-first, carry chained (optional WIDE_ADD_SUB_EN adds a subtract mode).
// Latency: accept at edge k -> out_valid after edge k+NUM_WORDS; in_ready only in IDLE, so accept completes the op before the next.
// Backpressure: result and c_out are held in DONE until out_ready; in_valid is ignored while busy.

module wide_add_word_adder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  c_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, c_in};
endmodule

module wide_add_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] op_a,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] op_b,
  input  logic                            c_in,
`ifdef WIDE_ADD_SUB_EN
  input  logic                            sub,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] result,
  output logic                            c_out,
  output logic                            busy
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  if (NUM_WORDS < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $error("wide_add_sequencer: NUM_WORDS and DATA_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic                                 carry_q;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] opa_q;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] opb_q;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] res_q;

  logic [DATA_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_co;

`ifdef WIDE_ADD_SUB_EN
  logic sub_q;
  // Subtraction is a + ~b + 1; the +1 enters through the initial carry.
  assign add_b = sub_q ? ~opb_q[idx] : opb_q[idx];
`else
  assign add_b = opb_q[idx];
`endif

  wide_add_word_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a     (opa_q[idx]),
    .b     (add_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_co)
  );

  assign result = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      c_out     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa_q    <= op_a;
            opb_q    <= op_b;
            idx      <= '0;
`ifdef WIDE_ADD_SUB_EN
            sub_q    <= sub;
            carry_q  <= sub ? 1'b1 : c_in;
`else
            carry_q  <= c_in;
`endif
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res_q[idx] <= add_sum;
          carry_q    <= add_co;
          if (idx == LAST_IDX) begin
            c_out     <= add_co;
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // No same-cycle re-accept: in_ready rises only once IDLE is reached.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: default 4x8 instance plus a 1x8 instance.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        c_in = 1'b0;
  logic        sub_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        c_out;
  logic        busy;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [7:0] op_a1 = '0;
  logic [7:0] op_b1 = '0;
  logic       c_in1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [7:0] result1;
  logic       c_out1;
  logic       busy1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.DATA_WIDTH(8), .NUM_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .c_in      (c_in),
`ifdef WIDE_ADD_SUB_EN
    .sub       (sub_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .busy      (busy)
  );

  wide_add_sequencer #(.DATA_WIDTH(8), .NUM_WORDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .op_a      (op_a1),
    .op_b      (op_b1),
    .c_in      (c_in1),
`ifdef WIDE_ADD_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .result    (result1),
    .c_out     (c_out1),
    .busy      (busy1)
  );

  // Stimulus only: accept one op with out_ready high, return the observed result and timing.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        output logic [31:0] r, output logic co, output int lat, output int bcnt);
    @(negedge clk);
    op_a = a; op_b = b; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1; bcnt = 0; r = '0; co = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      if (out_valid && lat < 0) begin
        lat = i; r = result; co = c_out;
      end
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got %h exp 00000000", result); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("FAIL reset_c_out got %b exp 0", c_out); end
    tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready1 got %b exp 1", in_ready1); end
  endtask

  task automatic test_basic_add;
    logic [31:0] r; logic co; int lat; int bcnt;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, co, lat, bcnt);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL basic_latency got %0d exp 4", lat); end
    tests_run++; if (bcnt !== 5) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d exp 5", bcnt); end
    tests_run++; if (r !== 32'h0000_0000) begin tests_failed++; $display("FAIL basic_result got %h exp 00000000", r); end
    tests_run++; if (co !== 1'b1) begin tests_failed++; $display("FAIL basic_c_out got %b exp 1", co); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready_after got %b exp 1", in_ready); end
    run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b1, r, co, lat, bcnt);
    tests_run++; if (r !== 32'h0001_FFFF) begin tests_failed++; $display("FAIL chain_result got %h exp 0001ffff", r); end
    tests_run++; if (co !== 1'b0) begin tests_failed++; $display("FAIL chain_c_out got %b exp 0", co); end
  endtask

  task automatic test_hold;
    int waited;
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Operands change right after accept and must not affect the sum.
    in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_BABE; c_in = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin @(negedge clk); waited++; end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_timeout out_valid got %b exp 1", out_valid); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_out_valid[%0d] got %b exp 1", i, out_valid); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); end
      tests_run++; if (result !== 32'h2345_678A) begin tests_failed++; $display("FAIL hold_result[%0d] got %h exp 2345678a", i, result); end
      tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("FAIL hold_c_out[%0d] got %b exp 0", i, c_out); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release_out_valid got %b exp 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_release_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL hold_no_stray_accept busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2; logic co1, co2;
    int n, t1, t2, ir_t, acc_t;
    n = 0; t1 = -1; t2 = -1; ir_t = -1; acc_t = -1;
    r1 = '0; r2 = '0; co1 = 1'b0; co2 = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; op_a = 32'h0000_00FF; op_b = 32'h0000_0001; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 32'h8000_0000; op_b = 32'h8000_0000;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        if (n == 0) begin r1 = result; co1 = c_out; t1 = i; end
        else begin r2 = result; co2 = c_out; t2 = i; end
        n++;
      end
      if (in_ready && ir_t < 0) ir_t = i;
      if (ir_t >= 0 && acc_t < 0 && busy) begin acc_t = i; in_valid = 1'b0; end
      if (n == 2) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++; if (r1 !== 32'h0000_0100) begin tests_failed++; $display("FAIL b2b_result1 got %h exp 00000100", r1); end
    tests_run++; if (co1 !== 1'b0) begin tests_failed++; $display("FAIL b2b_c_out1 got %b exp 0", co1); end
    tests_run++; if (r2 !== 32'h0000_0000) begin tests_failed++; $display("FAIL b2b_result2 got %h exp 00000000", r2); end
    tests_run++; if (co2 !== 1'b1) begin tests_failed++; $display("FAIL b2b_c_out2 got %b exp 1", co2); end
    tests_run++; if (t1 !== 4) begin tests_failed++; $display("FAIL b2b_first_done got %0d exp 4", t1); end
    tests_run++; if (acc_t !== 6) begin tests_failed++; $display("FAIL b2b_second_accept got %0d exp 6", acc_t); end
    tests_run++; if (t2 !== 10) begin tests_failed++; $display("FAIL b2b_second_done got %0d exp 10", t2); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic saw_ov;
    @(negedge clk);
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_in_ready got %b exp 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
    tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL abort_result got %h exp 00000000", result); end
    tests_run++; if (c_out !== 1'b0) begin tests_failed++; $display("FAIL abort_c_out got %b exp 0", c_out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b exp 0", busy); end
    saw_ov = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    tests_run++; if (saw_ov !== 1'b0) begin tests_failed++; $display("FAIL abort_no_completion got %b exp 0", saw_ov); end
  endtask

  task automatic test_single_word;
    @(negedge clk);
    op_a1 = 8'hFF; op_b1 = 8'h01; c_in1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    tests_run++; if (out_valid1 !== 1'b0) begin tests_failed++; $display("FAIL nw1_early_valid got %b exp 0", out_valid1); end
    tests_run++; if (busy1 !== 1'b1) begin tests_failed++; $display("FAIL nw1_busy got %b exp 1", busy1); end
    @(negedge clk);
    tests_run++; if (out_valid1 !== 1'b1) begin tests_failed++; $display("FAIL nw1_valid got %b exp 1", out_valid1); end
    tests_run++; if (result1 !== 8'h01) begin tests_failed++; $display("FAIL nw1_result got %h exp 01", result1); end
    tests_run++; if (c_out1 !== 1'b1) begin tests_failed++; $display("FAIL nw1_c_out got %b exp 1", c_out1); end
    out_ready1 = 1'b1;
    @(negedge clk);
    tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL nw1_in_ready got %b exp 1", in_ready1); end
    out_ready1 = 1'b0;
  endtask

`ifdef WIDE_ADD_SUB_EN
  task automatic test_subtract;
    logic [31:0] r; logic co; int lat; int bcnt;
    sub_sel = 1'b1;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, r, co, lat, bcnt);
    tests_run++; if (r !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL sub_borrow_result got %h exp fffffffe", r); end
    tests_run++; if (co !== 1'b0) begin tests_failed++; $display("FAIL sub_borrow_c_out got %b exp 0", co); end
    run_op(32'h0000_0007, 32'h0000_0005, 1'b0, r, co, lat, bcnt);
    tests_run++; if (r !== 32'h0000_0002) begin tests_failed++; $display("FAIL sub_result got %h exp 00000002", r); end
    tests_run++; if (co !== 1'b1) begin tests_failed++; $display("FAIL sub_c_out got %b exp 1", co); end
    sub_sel = 1'b0;
    run_op(32'h0000_0007, 32'h0000_0005, 1'b0, r, co, lat, bcnt);
    tests_run++; if (r !== 32'h0000_000C) begin tests_failed++; $display("FAIL sub_off_result got %h exp 0000000c", r); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_single_word();
`ifdef WIDE_ADD_SUB_EN
    test_subtract();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
